mdu_ctrl: RTL and testbench

Multiply/divide unit sequencer for the 5-stage pipeline.
- Accepts one MDU op per start pulse from the E stage and runs a fixed-latency multi-cycle multiply or divide.
- Owns the HI/LO registers and drives the pipeline stall that holds MDU-dependent instructions in D.
- Sits beside the E-stage ALU; the D-stage controller provides the dependency flag.

---
 rtl/mdu_ctrl.sv | 138 +++++++++++++
 tb/tb_mdu_ctrl.sv | 136 +++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// mdu_ctrl -- multiply/divide sequencer for the 5-stage pipeline.
//
// Accepts one MDU op per start pulse from E, runs a fixed-latency multiply
// or divide, owns HI/LO, and raises the D-stage stall for MDU-dependent
// instructions.
//
// Optional feature: define MDU_MADD_EN to enable MADD (op 6) / MSUB (op 7)
// accumulate into {hi,lo}. Without it, ops 6/7 are no-ops.
//
// Ports:
//   clk        pipeline clock, rising edge
//   reset      asynchronous, active-low
//   start      E-stage MDU instruction valid
//   op[2:0]    0 MULT,1 MULTU,2 DIV,3 DIVU,4 MTHI,5 MTLO,6 MADD,7 MSUB
//   a, b       rs / rt operands (forwarded)
//   d_use_mdu  D-stage instruction touches the MDU or HI/LO
//   busy       multi-cycle op in progress (registered)
//   stall      freeze PC and F/D, bubble into E (combinational)
//   hi, lo     HI/LO registers
module mdu_ctrl #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             d_use_mdu,
  output logic             busy,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q, b_q;
  logic [2:0]       op_q;

  // Decode of the incoming op (E stage)
  logic op_mul, op_div, op_acc, op_long;
  assign op_mul = (op == 3'd0) || (op == 3'd1);
  assign op_div = (op == 3'd2) || (op == 3'd3);
`ifdef MDU_MADD_EN
  assign op_acc = (op == 3'd6) || (op == 3'd7);
`else
  assign op_acc = 1'b0;
`endif
  assign op_long = op_mul | op_div | op_acc;

  // Stall also covers the start cycle so a dependent D instruction never
  // slips past before busy rises.
  assign stall = d_use_mdu & (busy | (start & op_long));

  // Results computed from latched operands; consumed only on the completion edge.
  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic signed [WIDTH-1:0] quo_s, rem_s;
  logic [WIDTH-1:0] quo_u, rem_u;

  assign prod_s = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q}) *
                  $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
  assign prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
  // SV signed / and % truncate toward zero, remainder takes dividend sign.
  assign quo_s  = $signed(a_q) / $signed(b_q);
  assign rem_s  = $signed(a_q) % $signed(b_q);
  assign quo_u  = a_q / b_q;
  assign rem_u  = a_q % b_q;

`ifdef MDU_MADD_EN
  // Accumulator is {hi,lo} as it stands at the completion edge.
  logic [2*WIDTH-1:0] acc;
  assign acc = op_q[0] ? ({hi, lo} - prod_s) : ({hi, lo} + prod_s);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (op_long) begin
              a_q   <= a;
              b_q   <= b;
              op_q  <= op;
              cnt   <= op_div ? DIV_N : MULT_N;
              busy  <= 1'b1;
              state <= RUN;
            end else if (op == 3'd4) begin
              hi <= a;
            end else if (op == 3'd5) begin
              lo <= a;
            end
          end
        end
        RUN: begin
          // start while busy is ignored (stall prevents it anyway)
          if (cnt == CW'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
            case (op_q)
              3'd0: {hi, lo} <= prod_s;
              3'd1: {hi, lo} <= prod_u;
              3'd2: if (b_q != '0) begin lo <= quo_s; hi <= rem_s; end
              3'd3: if (b_q != '0) begin lo <= quo_u; hi <= rem_u; end
`ifdef MDU_MADD_EN
              3'd6, 3'd7: {hi, lo} <= acc;
`endif
              default: ;
            endcase
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: drives on negedge, samples #1 after negedge.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        d_use_mdu;
  logic        busy, stall;
  logic [31:0] hi, lo;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mdu_ctrl #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .d_use_mdu(d_use_mdu), .busy(busy), .stall(stall), .hi(hi), .lo(lo)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one op at a negedge; expect busy for n cycles after the start edge.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int n, input logic dmu);
    start = 1'b1; op = o; a = x; b = y; d_use_mdu = dmu;
    #1;
    chk({tag, "_stall_start"}, stall, (dmu && n > 0));
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      #1;
      chk({tag, "_busy"}, busy, 1'b1);
      chk({tag, "_stall_busy"}, stall, dmu);
      @(negedge clk);
    end
    #1;
    chk({tag, "_busy_done"}, busy, 1'b0);
    chk({tag, "_stall_done"}, stall, 1'b0);
    d_use_mdu = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; d_use_mdu = 1'b0;
    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // MULT -3*7 with dependent D instruction
    run_op("mult", 3'd0, 32'hFFFFFFFD, 32'd7, 5, 1'b1);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFEB);

    // MULTU same operands, no dependency -> stall stays low
    run_op("multu", 3'd1, 32'hFFFFFFFD, 32'd7, 5, 1'b0);
    chk("multu_hi", hi, 32'h00000006);
    chk("multu_lo", lo, 32'hFFFFFFEB);

    run_op("divu", 3'd3, 32'd100, 32'd7, 10, 1'b0);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);

    run_op("div", 3'd2, 32'hFFFFFFF9, 32'd2, 10, 1'b1);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);

    // MTHI: single cycle, no busy, no stall
    run_op("mthi", 3'd4, 32'h12345678, 32'd0, 0, 1'b1);
    chk("mthi_hi", hi, 32'h12345678);
    chk("mthi_lo", lo, 32'hFFFFFFFD);

    // Divide by zero leaves HI/LO unchanged
    run_op("div0", 3'd2, 32'd55, 32'd0, 10, 1'b0);
    chk("div0_hi", hi, 32'h12345678);
    chk("div0_lo", lo, 32'hFFFFFFFD);

    // Async reset mid-MULT
    start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd4;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rmid_busy_pre", busy, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk("rmid_busy", busy, 1'b0);
    chk("rmid_hi", hi, 32'h0);
    chk("rmid_lo", lo, 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    chk("rpost_busy", busy, 1'b0);
    chk("rpost_hi", hi, 32'h0);
    chk("rpost_lo", lo, 32'h0);
    @(negedge clk);

    // Accumulate sequence
    run_op("mtlo", 3'd5, 32'd10, 32'd0, 0, 1'b0);
    chk("mtlo_lo", lo, 32'd10);
`ifdef MDU_MADD_EN
    run_op("madd", 3'd6, 32'd3, 32'd4, 5, 1'b1);
    chk("madd_hi", hi, 32'h0);
    chk("madd_lo", lo, 32'd22);
    run_op("msub", 3'd7, 32'd5, 32'd5, 5, 1'b1);
    chk("msub_hi", hi, 32'hFFFFFFFF);
    chk("msub_lo", lo, 32'hFFFFFFFD);
`else
    run_op("madd", 3'd6, 32'd3, 32'd4, 0, 1'b1);
    chk("madd_hi", hi, 32'h0);
    chk("madd_lo", lo, 32'd10);
    run_op("msub", 3'd7, 32'd5, 32'd5, 0, 1'b1);
    chk("msub_hi", hi, 32'h0);
    chk("msub_lo", lo, 32'd10);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
